// File: rtl/frame_pixel_sequencer.sv
// rtl/frame_pixel_sequencer.sv - raster pixel coordinate sequencer with frame control
//
// Walks (x,y) over a cfg_width x cfg_height frame in raster order and presents
// one pixel per beat on a valid/ready handshake. Dimensions are captured into
// shadow registers at frame start, so the inputs may change during a frame.
//
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   cfg_width, cfg_height  frame dimensions, sampled at frame start
//   start, stop            begin a frame (IDLE only) / end after current frame
//   continuous             repeat frames back-to-back, sampled at frame end
//   x_out, y_out           coordinates of the presented pixel
//   sof_out, eol_out       first pixel of frame / last pixel of line
//   valid_out, ready_in    pixel handshake; transfer = valid_out && ready_in
//   busy                   frame in progress
//   frame_done             pulse after the last pixel of a frame transfers
//   cfg_err                pulse when start is rejected for a zero dimension
//   frame_count            completed frames since reset, wrapping
module frame_pixel_sequencer #(
  parameter int DIM_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  output logic [DIM_W-1:0] x_out,
  output logic [DIM_W-1:0] y_out,
  output logic             sof_out,
  output logic             eol_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [DIM_W-1:0] w_shadow;
  logic [DIM_W-1:0] h_shadow;
  logic [DIM_W-1:0] x_cnt;
  logic [DIM_W-1:0] y_cnt;
  logic             stop_pending;

  logic last_x;
  logic last_y;
  logic cfg_ok;

  assign last_x = (x_cnt == w_shadow - DIM_ONE);
  assign last_y = (y_cnt == h_shadow - DIM_ONE);
  assign cfg_ok = (cfg_width != '0) && (cfg_height != '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= S_IDLE;
      w_shadow     <= '0;
      h_shadow     <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      stop_pending <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_pending <= 1'b0;
          if (start) begin
            if (cfg_ok) begin
              w_shadow <= cfg_width;
              h_shadow <= cfg_height;
              x_cnt    <= '0;
              y_cnt    <= '0;
              state    <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // A stop seen on any RUN cycle, including the last-pixel beat,
          // ends the run at the next frame boundary.
          stop_pending <= stop_pending | stop;
          if (ready_in) begin
            if (!last_x) begin
              x_cnt <= x_cnt + DIM_ONE;
            end else if (!last_y) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + DIM_ONE;
            end else begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + CNT_ONE;
              x_cnt       <= '0;
              y_cnt       <= '0;
              // Back-to-back frame needs a legal configuration; a zero
              // dimension at the boundary simply ends the run.
              if (continuous && !stop_pending && !stop && cfg_ok) begin
                w_shadow <= cfg_width;
                h_shadow <= cfg_height;
              end else begin
                state        <= S_IDLE;
                stop_pending <= 1'b0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid_out = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign x_out     = x_cnt;
  assign y_out     = y_cnt;
  assign sof_out   = valid_out && (x_cnt == '0) && (y_cnt == '0);
  assign eol_out   = valid_out && last_x;

endmodule

// File: tb/tb_frame_pixel_sequencer.sv
// tb/tb_frame_pixel_sequencer.sv - self-checking bench for frame_pixel_sequencer
module tb_frame_pixel_sequencer;

  logic        aclk;
  logic        areset;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [11:0] x_out;
  logic [11:0] y_out;
  logic        sof_out;
  logic        eol_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;
  logic [15:0] frame_count;

  frame_pixel_sequencer #(.DIM_W(12), .CNT_W(16)) dut (
    .aclk(aclk), .areset(areset), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .start(start), .stop(stop), .continuous(continuous), .x_out(x_out), .y_out(y_out),
    .sof_out(sof_out), .eol_out(eol_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .frame_count(frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a frame is a linear pixel index p over w*h pixels.
  bit m_run;
  int m_w, m_h, m_p;
  bit m_sp;
  int m_cnt;
  bit m_done, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_w = 0; m_h = 0; m_p = 0; m_sp = 0; m_cnt = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit stop_seen;
    if (areset) begin
      model_reset();
      return;
    end
    m_done = 0;
    m_err  = 0;
    if (!m_run) begin
      if (start) begin
        if (cfg_width != 0 && cfg_height != 0) begin
          m_run = 1; m_w = int'(cfg_width); m_h = int'(cfg_height); m_p = 0;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      stop_seen = m_sp | stop;
      m_sp = stop_seen;
      if (ready_in) begin
        if (m_p == m_w * m_h - 1) begin
          m_done = 1;
          m_cnt  = (m_cnt + 1) % 65536;
          m_p    = 0;
          if (continuous && !stop_seen && cfg_width != 0 && cfg_height != 0) begin
            m_w = int'(cfg_width); m_h = int'(cfg_height);
          end else begin
            m_run = 0; m_sp = 0;
          end
        end else begin
          m_p++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid_out", 32'(valid_out), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_run));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("frame_count", 32'(frame_count), 32'(m_cnt));
    chk("sof_out", 32'(sof_out), 32'(m_run && m_p == 0));
    chk("eol_out", 32'(eol_out), 32'(m_run && (m_p % m_w == m_w - 1)));
    if (m_run) begin
      chk("x_out", 32'(x_out), 32'(m_p % m_w));
      chk("y_out", 32'(y_out), 32'(m_p / m_w));
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_step();
    @(negedge aclk);
    compare_all();
  endtask

  initial begin
    int beats, dones, cnt0;
    bit seen;
    areset = 1'b1; cfg_width = 0; cfg_height = 0; start = 0; stop = 0;
    continuous = 0; ready_in = 0;
    model_reset();
    repeat (2) @(negedge aclk);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_count", 32'(frame_count), 0);
    areset = 1'b0;
    step();

    // 4x2 frame, ready held high
    cfg_width = 4; cfg_height = 2; ready_in = 1; start = 1;
    step();
    start = 0;
    for (int b = 0; b < 8; b++) begin
      chk("f42_valid", 32'(valid_out), 1);
      chk("f42_sof", 32'(sof_out), (b == 0) ? 1 : 0);
      chk("f42_eol", 32'(eol_out), (b == 3 || b == 7) ? 1 : 0);
      step();
    end
    chk("f42_done", 32'(frame_done), 1);
    chk("f42_count", 32'(frame_count), 1);
    chk("f42_idle", 32'(busy), 0);

    // Backpressure while presenting (2,0)
    start = 1;
    step();
    start = 0;
    step();
    step();
    ready_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_x", 32'(x_out), 2);
      chk("bp_y", 32'(y_out), 0);
      chk("bp_valid", 32'(valid_out), 1);
    end
    ready_in = 1;
    step();
    chk("bp_next_x", 32'(x_out), 3);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = frame_done;
    end
    chk("bp_done_seen", 32'(seen), 1);

    // Continuous: 3x1 then 2x2 (config changed mid-frame), stop during frame 2
    cnt0 = int'(frame_count);
    continuous = 1; cfg_width = 3; cfg_height = 1; start = 1;
    step();
    start = 0; cfg_width = 2; cfg_height = 2;
    beats = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (!valid_out) break;
      beats++;
      stop = (beats == 5);
      step();
      if (frame_done) dones++;
    end
    stop = 0; continuous = 0;
    chk("cont_beats", 32'(beats), 7);
    chk("cont_dones", 32'(dones), 2);
    chk("cont_idle", 32'(busy), 0);
    chk("cont_count", 32'(int'(frame_count) - cnt0), 2);

    // Zero width rejected
    cfg_width = 0; cfg_height = 3; start = 1;
    step();
    start = 0;
    chk("zero_err", 32'(cfg_err), 1);
    chk("zero_valid", 32'(valid_out), 0);
    chk("zero_busy", 32'(busy), 0);
    step();
    chk("zero_err_clr", 32'(cfg_err), 0);

    // 1x1 frame
    cfg_width = 1; cfg_height = 1; start = 1;
    step();
    start = 0;
    chk("one_sof", 32'(sof_out), 1);
    chk("one_eol", 32'(eol_out), 1);
    chk("one_valid", 32'(valid_out), 1);
    step();
    chk("one_done", 32'(frame_done), 1);
    chk("one_valid_after", 32'(valid_out), 0);

    // Reset at pixel (1,1) of an 8x8 frame
    cfg_width = 8; cfg_height = 8; start = 1;
    step();
    start = 0;
    repeat (9) step();
    chk("r88_x", 32'(x_out), 1);
    chk("r88_y", 32'(y_out), 1);
    areset = 1;
    #1;
    chk("r88_valid", 32'(valid_out), 0);
    chk("r88_count", 32'(frame_count), 0);
    chk("r88_xrst", 32'(x_out), 0);
    model_reset();
    step();
    areset = 0;
    start = 1;
    step();
    start = 0;
    chk("r88_restart_x", 32'(x_out), 0);
    chk("r88_restart_y", 32'(y_out), 0);
    chk("r88_restart_sof", 32'(sof_out), 1);

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom % 8) == 0;
      stop     = ($urandom % 25) == 0;
      ready_in = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) continuous = $urandom % 2;
      cfg_width  = 12'($urandom % 6);
      cfg_height = 12'($urandom % 4);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/frame_pixel_sequencer.md
FRAME_PIXEL_SEQUENCER -- requirements
Module: frame_pixel_sequencer

Interface
REQ-001 SHALL have parameter DIM_W, default 12, bit width of the pixel coordinates and frame dimensions.
REQ-002 SHALL have parameter CNT_W, default 16, bit width of the completed-frame counter.
REQ-003 SHALL have port aclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_width, input, DIM_W, pixels per line; sampled only at frame start.
REQ-006 SHALL have port cfg_height, input, DIM_W, lines per frame; sampled only at frame start.
REQ-007 SHALL have port start, input, 1, single-cycle request to begin a frame; honoured only in IDLE.
REQ-008 SHALL have port stop, input, 1, single-cycle request to end after the current frame.
REQ-009 SHALL have port continuous, input, 1, when 1, frames repeat back-to-back; sampled at each frame end.
REQ-010 SHALL have port x_out, output, DIM_W, column of the presented pixel.
REQ-011 SHALL have port y_out, output, DIM_W, line of the presented pixel.
REQ-012 SHALL have port sof_out, output, 1, presented pixel is (0,0).
REQ-013 SHALL have port eol_out, output, 1, presented pixel is the last in its line.
REQ-014 SHALL have port valid_out, output, 1, presented pixel is valid.
REQ-015 SHALL have port ready_in, input, 1, downstream pixel consumer accepts; transfer = valid_out && ready_in.
REQ-016 SHALL have port busy, output, 1, state is RUN.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame transfers.
REQ-018 SHALL have port cfg_err, output, 1, one-cycle pulse when start is rejected because of a zero dimension.
REQ-019 SHALL have port frame_count, output, CNT_W, completed frames since reset; wraps modulo 2^CNT_W.

Function
REQ-020 SHALL implement two states: IDLE and RUN.
REQ-021 In IDLE, start=1 with cfg_width!=0 and cfg_height!=0 SHALL latch both dimensions into shadow registers, clear x/y to 0 and enter RUN; valid_out=1 with sof_out=1 from the next cycle (latency 1).
REQ-022 In IDLE, start=1 with either dimension 0 SHALL pulse cfg_err in the next cycle and remain in IDLE.
REQ-023 In RUN, valid_out SHALL be 1, and x_out/y_out SHALL be held stable until a transfer occurs.
REQ-024 sof_out SHALL equal (x==0 && y==0); eol_out SHALL equal (x==w_shadow-1); both are qualified by valid_out and are 0 in IDLE.
REQ-025 On a transfer with eol_out=0, x SHALL increment; with eol_out=1 and y!=h_shadow-1, x SHALL clear and y SHALL increment.
REQ-026 On transfer of the last pixel (x=w-1, y=h-1), the block SHALL pulse frame_done and increment frame_count in the next cycle.
REQ-027 At that point, if continuous=1 and no stop is pending, the block SHALL relatch cfg_width/cfg_height, clear x/y and stay in RUN with no idle cycle; otherwise it SHALL enter IDLE with valid_out=0.
REQ-028 stop in RUN SHALL set stop_pending, which is cleared on entry to IDLE; stop in IDLE SHALL have no effect.
REQ-029 stop on the same cycle as the last-pixel transfer SHALL end the run after that frame.
REQ-030 start in RUN SHALL be ignored.
REQ-031 Changes to cfg_width/cfg_height during a frame SHALL NOT affect that frame.
REQ-032 A 1x1 frame SHALL present a single beat with sof_out=1, eol_out=1, followed by frame_done.

Reset
REQ-033 areset=1 SHALL immediately force IDLE, valid_out=0, busy=0, frame_done=0, cfg_err=0, x_out=0, y_out=0, frame_count=0, shadow dimensions=0, stop_pending=0, including in the middle of a frame.
REQ-034 After areset is deasserted, the block SHALL wait in IDLE for start.

Verification
REQ-035 w=4, h=2, ready_in=1, start pulse -> 8 beats on consecutive cycles; sof_out on beat 0; eol_out on beats 3 and 7; frame_done one cycle after beat 7; frame_count=1; back in IDLE.
REQ-036 w=4, h=2, ready_in=0 for 3 cycles while presenting (2,0) -> x_out=2, y_out=0, valid_out=1 held for all 3 cycles; no skipped or repeated pixel.
REQ-037 continuous=1, cfg changed to 2x2 during the first 3x1 frame -> frame 1 = 3 beats, frame 2 = 4 beats with no gap; stop during frame 2 -> frame 2 completes, then IDLE; frame_count=2.
REQ-038 start with cfg_width=0 -> cfg_err pulse, valid_out stays 0, busy=0.
REQ-039 1x1 frame -> single beat with sof_out=eol_out=1, then frame_done; also areset asserted at pixel (1,1) of an 8x8 frame -> valid_out=0 immediately, and the next start begins at (0,0).
